max_unpool_stream: RTL and testbench

Streaming 2x2 max-unpooling block: the inverse of the 2x2 max-pooling stage. It accepts pooled pixels plus their 2-bit argmax position and produces the full-resolution feature map in raster order. Each pooled value is placed at its recorded position and the other three positions are zero; a replicate mode instead copies the value to all four positions. The block serves the decoder/upsampling path and supports the 2-channel, 14x14 to 28x28 geometry used by the pooling stage.

---
 rtl/max_unpool_stream.sv | 130 +++++++++++++
 tb/tb_max_unpool_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpool_stream.sv
// Streaming 2x2 max-unpooling: buffers one pooled row, then emits the two
// full-resolution rows it expands to, either zero-filled around the argmax
// position or replicated into all four positions.
module max_unpool_stream #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned IN_DIM   = 14,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic [1:0]          in_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_last
);

  localparam int unsigned ColW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned OutColW = ColW + 1;
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [ColW-1:0]    ColMax    = ColW'(IN_DIM - 1);
  localparam logic [OutColW-1:0] OutColMax = OutColW'(2 * IN_DIM - 1);
  localparam logic [ChW-1:0]     ChMax     = ChW'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StEmit} state_e;

  state_e state_q, state_d;

  logic [ColW-1:0]    in_col_q;
  logic [ColW-1:0]    prow_q;
  logic [ChW-1:0]     ch_q;
  logic               s_q;
  logic [OutColW-1:0] c_q;
  logic               mode_q;

  logic [BITWIDTH-1:0] buf_val [IN_DIM];
  logic [1:0]          buf_idx [IN_DIM];

  logic                in_fire;
  logic                out_fire;
  logic                first_beat;
  logic [ColW-1:0]     rd_j;
  logic [1:0]          rd_pos;

  assign in_fire    = (state_q == StFill) && in_valid;
  assign out_fire   = (state_q == StEmit) && out_ready;
  assign first_beat = (prow_q == '0) && (ch_q == '0) && (in_col_q == '0);
  assign rd_j       = c_q[OutColW-1:1];
  // Window position of the current output pixel: bit1 = odd column, bit0 = odd row.
  assign rd_pos     = {c_q[0], s_q};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFill;
      StFill: begin
        in_ready = 1'b1;
        if (in_valid && (in_col_q == ColMax)) state_d = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        if (mode_q || (buf_idx[rd_j] == rd_pos)) out_data = buf_val[rd_j];
        out_last  = (ch_q == ChMax) && (prow_q == ColMax) && s_q && (c_q == OutColMax);
        if (out_ready && s_q && (c_q == OutColMax)) state_d = StFill;
      end
      default: state_d = StIdle;
    endcase
  end

  // Position counters and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_col_q <= '0;
      prow_q   <= '0;
      ch_q     <= '0;
      s_q      <= 1'b0;
      c_q      <= '0;
      mode_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        if (first_beat) mode_q <= mode;
        in_col_q <= (in_col_q == ColMax) ? '0 : in_col_q + 1'b1;
      end
      if (out_fire) begin
        if (c_q == OutColMax) begin
          c_q <= '0;
          s_q <= ~s_q;
          if (s_q) begin
            if (prow_q == ColMax) begin
              prow_q <= '0;
              ch_q   <= (ch_q == ChMax) ? '0 : ch_q + 1'b1;
            end else begin
              prow_q <= prow_q + 1'b1;
            end
          end
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  // Row buffer write; contents are only read after a full row has been written.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_val[in_col_q] <= in_data;
      buf_idx[in_col_q] <= in_idx;
    end
  end

endmodule

// File: tb/tb_max_unpool_stream.sv
// Directed bench for max_unpool_stream: reset, unpool/replicate rows,
// backpressure, full frames and a reset in the middle of EMIT.
module tb_max_unpool_stream;

  localparam int BW   = 16;
  localparam int N    = 14;
  localparam int OW   = 2 * N;
  localparam int ROWS = 2 * N;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BW-1:0] in_data = '0;
  logic [1:0]           in_idx = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [BW-1:0] out_data;
  logic                 out_last;

  int checks = 0;
  int errors = 0;

  logic signed [BW-1:0] rv  [N];
  logic [1:0]           ri  [N];
  logic signed [BW-1:0] got [4*N];
  logic                 exp_mode = 1'b0;
  int                   row0_exp [10] = '{1, 0, 0, 0, 0, 3, 0, 0, 5, 0};
  int                   row1_exp [10] = '{0, 0, 2, 0, 0, 0, 0, 4, 0, 0};

  max_unpool_stream #(
    .BITWIDTH(BW),
    .IN_DIM  (N),
    .CHANNELS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_idx   (in_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [BW-1:0] model(input int s, input int c);
    int         j;
    logic [1:0] p;
    j = c / 2;
    p = 2'(((c % 2) * 2) + s);
    if (exp_mode) return rv[j];
    return (ri[j] == p) ? rv[j] : '0;
  endfunction

  // kind 0: value j+1 / idx j%4; kind 1: all -5 with random idx; else random.
  task automatic gen_row(input int kind);
    for (int j = 0; j < N; j++) begin
      if (kind == 0) begin
        rv[j] = BW'(j + 1);
        ri[j] = 2'(j % 4);
      end else if (kind == 1) begin
        rv[j] = -16'sd5;
        ri[j] = 2'($urandom_range(0, 3));
      end else begin
        rv[j] = BW'($urandom);
        ri[j] = 2'($urandom);
      end
    end
  endtask

  task automatic send_row(input logic m_first, input logic m_rest, input bit gaps);
    bit acc;
    int cyc;
    for (int j = 0; j < N; j++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = rv[j];
      in_idx   = ri[j];
      mode     = (j == 0) ? m_first : m_rest;
      acc      = 1'b0;
      cyc      = 0;
      while (!acc && cyc < 50) begin
        if (in_ready) chk("fill_out_valid", out_valid, 0);
        acc = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) chk("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_row(input int row, input bit bp, input bit last_row, input int stop_at);
    int                   n;
    int                   cyc;
    bit                   prev_stall;
    logic signed [BW-1:0] prev;
    n          = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev       = '0;
    while (n < stop_at && cyc < 400) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      chk($sformatf("emit_valid r%0d", row), out_valid, 1);
      chk($sformatf("emit_in_ready r%0d", row), in_ready, 0);
      if (prev_stall) chk($sformatf("stall_hold r%0d b%0d", row, n), out_data, prev);
      if (out_ready && out_valid) begin
        chk($sformatf("data r%0d b%0d", row, n), out_data, model(n / OW, n % OW));
        chk($sformatf("last r%0d b%0d", row, n), out_last, (last_row && n == 4 * N - 1));
        got[n] = out_data;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev       = out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("beat_count r%0d", row), n, stop_at);
  endtask

  task automatic after_row(input int row);
    chk($sformatf("ready_after_emit r%0d", row), in_ready, 1);
    chk($sformatf("idle_out_valid r%0d", row), out_valid, 0);
  endtask

  initial begin
    // Reset held with live handshakes on both sides.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", in_ready, 1);

    // Frame A, unpool: directed row 0, backpressured row 1, random rows with gaps.
    exp_mode = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      gen_row((r == 0) ? 0 : 2);
      send_row(1'b0, 1'b0, r >= 2);
      recv_row(r, r == 1, r == ROWS - 1, 4 * N);
      if (r == 0) begin
        for (int k = 0; k < 10; k++) begin
          chk($sformatf("row0_lit b%0d", k), got[k], row0_exp[k]);
          chk($sformatf("row1_lit b%0d", k), got[OW + k], row1_exp[k]);
        end
      end
      after_row(r);
    end

    // Frame B, replicate latched at frame start; mode input drops to 0 after beat 0.
    exp_mode = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      gen_row((r == 0) ? 1 : 2);
      send_row((r == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      recv_row(100 + r, 1'b0, r == ROWS - 1, 4 * N);
      if (r == 0) begin
        for (int k = 0; k < 4 * N; k += 9) chk($sformatf("repl_m5 b%0d", k), got[k], -5);
      end
      after_row(100 + r);
    end

    // Frame C, back-to-back random unpool frame.
    exp_mode = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      gen_row(2);
      send_row(1'b0, 1'b0, 1'b1);
      recv_row(200 + r, 1'b0, r == ROWS - 1, 4 * N);
      after_row(200 + r);
    end

    // Frame D: reset at output beat 30 of row 5.
    for (int r = 0; r < 6; r++) begin
      gen_row(2);
      send_row(1'b0, 1'b0, 1'b0);
      recv_row(300 + r, 1'b0, 1'b0, (r == 5) ? 30 : 4 * N);
      if (r < 5) after_row(300 + r);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after_release", in_ready, 1);
    // Fresh frame start must re-latch mode; replicate proves counters restarted.
    exp_mode = 1'b1;
    gen_row(2);
    send_row(1'b1, 1'b1, 1'b0);
    recv_row(400, 1'b0, 1'b0, 4 * N);
    after_row(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
